memory_controller: RTL

- Sits between the load/store buffer (LSB), the instruction fetcher (IF) and the byte-wide unified RAM/IO bus.
- Serialises 1/2/4-byte LSB loads and stores and 4-byte instruction fetches into per-byte RAM cycles.
- Byte order is little-endian. LSB requests have priority over IF requests.
- Returns one-cycle ready pulses with the assembled data, and aborts speculative reads on ROB rollback.

---
 rtl/memory_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_controller.sv
// memory_controller: serialises LSB loads/stores and IF fetches into byte-wide RAM/IO cycles.
// Optional IO-store back-pressure (IO_WAIT) is built only when MC_IO_STALL_EN is defined.
module memory_controller #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned IF_GOAL    = 4,
   parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsb_request_in,
   input  logic                  lsb_rw_signal_in,
   input  logic [ADDR_WIDTH-1:0] lsb_address_in,
   input  logic [2:0]            lsb_goal_in,
   input  logic [31:0]           lsb_data_in,
   output logic                  lsb_ready_out,
   output logic [31:0]           lsb_data_out,
   input  logic                  if_request_in,
   input  logic [ADDR_WIDTH-1:0] if_address_in,
   output logic                  if_ready_out,
   output logic [31:0]           if_inst_out,
   input  logic                  rob_rollback_in,
   input  logic                  io_buffer_full_in,
   output logic                  ram_rw_out,
   output logic [ADDR_WIDTH-1:0] ram_address_out,
   output logic [7:0]            ram_data_out,
   input  logic [7:0]            ram_data_in
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

   typedef struct packed {
      logic                  rw;
      logic                  is_if;
      logic [ADDR_WIDTH-1:0] addr;
      logic [CNT_W-1:0]      goal;
      logic [DATA_W-1:0]     data;
   } op_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   op_t                  cur, cur_nxt;
   op_t                  pend, pend_nxt;
   logic                 pend_valid, pend_valid_nxt;
   logic [DATA_W-1:0]    rd_buf, rd_buf_nxt;
   logic                 lsb_ready_nxt, if_ready_nxt, ram_rw_nxt;
   logic [DATA_W-1:0]    lsb_data_nxt, if_inst_nxt;
   logic [ADDR_WIDTH-1:0] ram_addr_nxt;
   logic [7:0]           ram_wdata_nxt;

   logic                 req_ok_c, start_c, io_stall_c;
   op_t                  live_op_c, start_op_c;
   logic [1:0]           byte_idx_c;

   // Byte i of a read is captured at counter value i+2.
   assign byte_idx_c = 2'(cnt - CNT_W'(2));

`ifndef MC_IO_STALL_EN
   logic unused_io_full_c;
   assign unused_io_full_c = io_buffer_full_in;
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      cur_nxt        = cur;
      pend_nxt       = pend;
      pend_valid_nxt = pend_valid;
      rd_buf_nxt     = rd_buf;
      lsb_ready_nxt  = 1'b0;
      if_ready_nxt   = 1'b0;
      lsb_data_nxt   = lsb_data_out;
      if_inst_nxt    = if_inst_out;
      ram_rw_nxt     = ram_rw_out;
      ram_addr_nxt   = ram_address_out;
      ram_wdata_nxt  = ram_data_out;
      start_c        = 1'b0;
      start_op_c     = '0;
      io_stall_c     = 1'b0;

      live_op_c       = '0;
      live_op_c.rw    = lsb_rw_signal_in;
      live_op_c.addr  = lsb_address_in;
      live_op_c.goal  = lsb_goal_in;
      live_op_c.data  = lsb_data_in;
      // On rollback only stores (already committed) may be accepted.
      req_ok_c = lsb_request_in && (lsb_rw_signal_in || !rob_rollback_in);

      if (pend_valid && rob_rollback_in && !pend.rw) pend_valid_nxt = 1'b0;
      if (state != IDLE && req_ok_c) begin
         pend_valid_nxt = 1'b1;
         pend_nxt       = live_op_c;
      end

      unique case (state)
         IDLE: begin
            if (pend_valid && (pend.rw || !rob_rollback_in)) begin
               start_c        = 1'b1;
               start_op_c     = pend;
               pend_valid_nxt = 1'b0;
            end else if (req_ok_c) begin
               start_c    = 1'b1;
               start_op_c = live_op_c;
            end else if (if_request_in && !rob_rollback_in) begin
               start_c          = 1'b1;
               start_op_c.is_if = 1'b1;
               start_op_c.addr  = if_address_in;
               start_op_c.goal  = CNT_W'(IF_GOAL);
            end
         end
         READ: begin
            if (rob_rollback_in) begin
               state_nxt  = IDLE;
               ram_rw_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt >= CNT_W'(2)) rd_buf_nxt[{byte_idx_c, 3'b000} +: 8] = ram_data_in;
               if (cnt < cur.goal) ram_addr_nxt = cur.addr + ADDR_WIDTH'(cnt);
               if (cnt == cur.goal + CNT_W'(1)) begin
                  state_nxt = IDLE;
                  if (cur.is_if) begin
                     if_ready_nxt = 1'b1;
                     if_inst_nxt  = rd_buf_nxt;
                  end else begin
                     lsb_ready_nxt = 1'b1;
                     lsb_data_nxt  = rd_buf_nxt;
                  end
               end
            end
         end
         WRITE: begin
            if (cnt < cur.goal) begin
               ram_rw_nxt    = 1'b1;
               ram_addr_nxt  = cur.addr + ADDR_WIDTH'(cnt);
               ram_wdata_nxt = cur.data[{cnt[1:0], 3'b000} +: 8];
               cnt_nxt       = cnt + CNT_W'(1);
            end else begin
               ram_rw_nxt    = 1'b0;
               lsb_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
`ifdef MC_IO_STALL_EN
         IO_WAIT: begin
            if (!io_buffer_full_in) begin
               state_nxt     = WRITE;
               cnt_nxt       = CNT_W'(1);
               ram_rw_nxt    = 1'b1;
               ram_addr_nxt  = cur.addr;
               ram_wdata_nxt = cur.data[7:0];
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Launch the chosen op and drive its byte 0 right after the start edge.
      if (start_c) begin
`ifdef MC_IO_STALL_EN
         io_stall_c = start_op_c.rw && (start_op_c.addr[17:16] == IO_ADDR_HI) && io_buffer_full_in;
`endif
         cur_nxt    = start_op_c;
         cnt_nxt    = CNT_W'(1);
         rd_buf_nxt = '0;
         if (!start_op_c.rw) begin
            state_nxt    = READ;
            ram_rw_nxt   = 1'b0;
            ram_addr_nxt = start_op_c.addr;
         end else if (io_stall_c) begin
            state_nxt  = IO_WAIT;
            ram_rw_nxt = 1'b0;
         end else begin
            state_nxt     = WRITE;
            ram_rw_nxt    = 1'b1;
            ram_addr_nxt  = start_op_c.addr;
            ram_wdata_nxt = start_op_c.data[7:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         cnt             <= '0;
         cur             <= '0;
         pend            <= '0;
         pend_valid      <= 1'b0;
         rd_buf          <= '0;
         lsb_ready_out   <= 1'b0;
         lsb_data_out    <= '0;
         if_ready_out    <= 1'b0;
         if_inst_out     <= '0;
         ram_rw_out      <= 1'b0;
         ram_address_out <= '0;
         ram_data_out    <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         cur             <= cur_nxt;
         pend            <= pend_nxt;
         pend_valid      <= pend_valid_nxt;
         rd_buf          <= rd_buf_nxt;
         lsb_ready_out   <= lsb_ready_nxt;
         lsb_data_out    <= lsb_data_nxt;
         if_ready_out    <= if_ready_nxt;
         if_inst_out     <= if_inst_nxt;
         ram_rw_out      <= ram_rw_nxt;
         ram_address_out <= ram_addr_nxt;
         ram_data_out    <= ram_wdata_nxt;
      end
   end

endmodule
